fifo_ms_merge: RTL
==================

// Module: fifo_ms_merge
// PURPOSE
// - Multi-stream merging FIFO: FLUX producers each push untagged payloads into a private lane queue;
//   one consumer pops a single tagged stream. This is the N-writers/1-reader counterpart of the tagged-demux FIFO.
// - Output word = {lane index (TAG_WIDTH MSBs), payload}, so the downstream demux FIFO can route it back by tag.
// PARAMETERS
// - WIDTH  8  output word width, tag included
// - DEPTH  4  entries per lane; power of 2, >=2
// - FLUX   2  number of lanes/producers; >=2
// - RR     1  1 = round-robin arbitration, 0 = fixed priority (highest lane index wins)
// - derived: TAG_WIDTH = $clog2(FLUX); PAY_WIDTH = WIDTH-TAG_WIDTH; ADDR_WIDTH = $clog2(DEPTH)
// PORTS
// - ck       in   1                  clock, all state on posedge
// - rst_n    in   1                  asynchronous reset, active-low
// - wr       in   FLUX               per-lane write strobe
// - datain   in   FLUX*PAY_WIDTH     lane i payload at [i*PAY_WIDTH +: PAY_WIDTH]
// - full     out  FLUX               lane i holds DEPTH entries
// - rd       in   1                  consumer pop request
// - empty    out  1                  no valid word at dataout
// - dataout  out  WIDTH              {tag, payload}; valid while empty==0
// BEHAVIOUR
// - Reset (rst_n low, async): all lane counts/pointers 0, full=0, empty=1, dataout=0, RR pointer=FLUX-1.
//   Mid-operation reset discards all stored and presented data; nothing stale after release.
// - Lane write: accepted on posedge iff wr[i] && !full[i] (full sampled pre-edge); otherwise dropped silently, no state change.
//   All lanes may be written in the same cycle.
// - Lane i: circular buffer, Wp/Rp ADDR_WIDTH bits wrap DEPTH-1 -> 0; count 0..DEPTH (ADDR_WIDTH+1 bits).
//   full[i] = (count==DEPTH), registered-state derived; no combinational path from wr/rd.
// - Output stage: one register {valid, dataout}; empty = ~valid (first-word-fall-through).
//   - rd while empty=1: ignored.
//   - load condition: (!valid || rd) && any lane count>0 -> dataout <= {grant, head[grant]}, pop lane grant, valid<=1.
//   - (!valid || rd) with all lanes empty: valid<=0, dataout holds last value.
//   - rd with valid=1 and no load: valid<=0.
// - Latency: write on edge k into idle block -> empty=0, data on dataout after edge k+1. Back-to-back rd sustains 1 word/cycle.
// - Arbitration (evaluated on pre-edge counts only; a word written on the same edge is not eligible):
//   - RR=1: search lanes ascending from (ptr+1) mod FLUX; first non-empty wins; ptr<=grant on load only.
//   - RR=0: highest non-empty index wins.
// - Simultaneous write to and pop from same lane: both take effect; count unchanged.
//   Write to a full lane in the cycle it is popped: write dropped (full pre-edge), full clears next cycle.
// - Per-lane order preserved; inter-lane order defined solely by arbitration.
// STRUCTURE
// - Shared header fifo_ms_defs.vh: TAG_WIDTH/PAY_WIDTH/ADDR_WIDTH derivations, tag field slice macro
//   (also used by the tagged-demux FIFO so both ends agree on tag placement).
// - Sub-module fifo_ms_lane (one per lane, generate loop): circular buffer, ports ck, rst_n, push, pop,
//   din, head, count, full.
// - Top: lane array, arbiter (RR pointer + priority search), output register.
// TESTING (FLUX=2, WIDTH=8, DEPTH=4, RR=1, PAY_WIDTH=7)
// - Reset: rst_n=0 -> empty=1, full=2'b00, dataout=8'h00 immediately, no clock needed.
// - Single word: wr=2'b01, lane0 payload 7'h15 one cycle -> empty=0 after next edge, dataout=8'h15; rd 1 cycle -> empty=1.
// - Fill/overflow: lane1 writes 7'h01..7'h04 -> full=2'b10; 5th write 7'h05 dropped;
//   4 reads -> 8'h81,8'h82,8'h83,8'h84, then empty=1.
// - Round-robin: lane0 preloaded 7'h10..12, lane1 7'h20..22, rd held high
//   -> 8'h10,8'hA0,8'h11,8'hA1,8'h12,8'hA2, then empty=1.
// - Full-lane write during pop: lane0 full, wr[0]=1 with 7'h7F and rd same cycle
//   -> 7'h7F never appears at dataout; full[0]=0 next cycle.
// - Reset mid-stream: 3 words queued, rst_n pulsed low -> empty=1 at once; after release rd yields nothing.

Source files
------------

// File: rtl/fifo_ms_merge_pkg.sv
// Shared definitions for the multi-stream merging FIFO: arbitration modes,
// tag placement helpers and the round-robin lane search step.
package fifo_ms_merge_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Tag occupies the TAG_WIDTH MSBs of the output word; the demux end uses the same slice.
    function automatic int tag_lsb(input int width, input int tag_width);
        return width - tag_width;
    endfunction

    // Lane visited at step k (1..flux) of a search that starts just after ptr.
    function automatic int rr_lane(input int ptr, input int k, input int flux);
        int idx;
        idx = ptr + k;
        if (idx >= flux) begin
            idx = idx - flux;
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_ms_lane.sv
// One producer lane: circular buffer with registered occupancy count.
// The head word is presented combinationally from the read pointer.
module fifo_ms_lane #(
    parameter int PAY_WIDTH = 7,
    parameter int DEPTH     = 4,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  ck,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [PAY_WIDTH-1:0]  din,
    output logic [PAY_WIDTH-1:0]  head,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full
);

    logic [PAY_WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wp;
    logic [ADDR_WIDTH-1:0] rp;
    logic                  push_ok;
    logic                  pop_ok;

    // Full and empty come from registered count only, so a push to a full
    // lane is dropped even when the same edge pops it.
    assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rp];

    always_ff @(posedge ck) begin
        if (push_ok) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wp <= wp + 1'b1;
            end
            if (pop_ok) begin
                rp <= rp + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_ms_merge.sv
// N-writer / 1-reader merging FIFO: per-lane queues, an arbiter that picks
// the next lane, and a first-word-fall-through output register tagging each word.
module fifo_ms_merge
    import fifo_ms_merge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int FLUX  = 2,
    parameter int RR    = ARB_RR,
    localparam int TAG_WIDTH  = $clog2(FLUX),
    localparam int PAY_WIDTH  = WIDTH - TAG_WIDTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                      ck,
    input  logic                      rst_n,
    input  logic [FLUX-1:0]           wr,
    input  logic [FLUX*PAY_WIDTH-1:0] datain,
    output logic [FLUX-1:0]           full,
    input  logic                      rd,
    output logic                      empty,
    output logic [WIDTH-1:0]          dataout
);

    localparam int TAG_LSB = tag_lsb(WIDTH, TAG_WIDTH);

    logic [PAY_WIDTH-1:0]  head     [FLUX];
    logic [ADDR_WIDTH:0]   count    [FLUX];
    logic [FLUX-1:0]       nonempty;
    logic [FLUX-1:0]       pop;
    logic [TAG_WIDTH-1:0]  grant;
    logic [TAG_WIDTH-1:0]  rr_ptr;
    logic                  any;
    logic                  valid;
    logic                  load;

    genvar gi;
    generate
        for (gi = 0; gi < FLUX; gi++) begin : g_lane
            fifo_ms_lane #(
                .PAY_WIDTH (PAY_WIDTH),
                .DEPTH     (DEPTH)
            ) u_lane (
                .ck    (ck),
                .rst_n (rst_n),
                .push  (wr[gi]),
                .pop   (pop[gi]),
                .din   (datain[gi*PAY_WIDTH +: PAY_WIDTH]),
                .head  (head[gi]),
                .count (count[gi]),
                .full  (full[gi])
            );
            assign nonempty[gi] = (count[gi] != '0);
            assign pop[gi]      = load && (grant == TAG_WIDTH'(gi));
        end
    endgenerate

    // Arbitration sees pre-edge counts, so a word written on this edge waits a cycle.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        if (RR == ARB_RR) begin
            for (int k = 1; k <= FLUX; k++) begin
                if (!any && nonempty[rr_lane(int'(rr_ptr), k, FLUX)]) begin
                    any   = 1'b1;
                    grant = TAG_WIDTH'(rr_lane(int'(rr_ptr), k, FLUX));
                end
            end
        end else begin
            for (int i = FLUX - 1; i >= 0; i--) begin
                if (!any && nonempty[i]) begin
                    any   = 1'b1;
                    grant = TAG_WIDTH'(i);
                end
            end
        end
    end

    // Consumer handshake: a word is offered while empty==0; asserting rd on an
    // edge pops that word, and rd while empty==1 is ignored.
    assign load  = (!valid || rd) && any;
    assign empty = !valid;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            dataout <= '0;
            rr_ptr  <= TAG_WIDTH'(FLUX - 1);
        end else if (load) begin
            valid                       <= 1'b1;
            dataout[WIDTH-1:TAG_LSB]    <= grant;
            dataout[PAY_WIDTH-1:0]      <= head[grant];
            if (RR == ARB_RR) begin
                rr_ptr <= grant;
            end
        end else if (!valid || rd) begin
            valid <= 1'b0;
        end
    end

endmodule
